// File: rtl/multicycle_control.sv
// multicycle_control
// Main controller for a multicycle MIPS datapath. A Moore FSM sequences every
// instruction (R-type, LW, SW, BEQ, ADDI, J, JAL) over several cycles. It drives
// the shared memory, IR, PC, register-file and ALU-source controls.
// Memory states can wait on a ready handshake, with an optional timeout.
//
// Ports
//   clk                      rising-edge clock
//   reset                    synchronous, active-high; forces FETCH, all outputs 0
//   Opcode[5:0]              IR[31:26], valid from DECODE onward
//   mem_ready                memory finishes the current read/write this cycle
//   PCWrite .. JALFlag       single-bit datapath controls
//   PCSource[1:0]            00 ALU result, 01 ALUOut, 10 jump target
//   ALUOp[1:0]               00 add, 01 subtract, 10 funct-decoded
//   ALUSrcB[1:0]             00 reg B, 01 const 4, 10 imm, 11 imm<<2
//   state[3:0]               current state code (debug)
//   instr_done               pulse in the final cycle of each instruction
//   illegal_op               pulse in DECODE on an unsupported opcode
//   mem_fault                pulse when a memory state times out
module multicycle_control #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int MEM_TIMEOUT   = 15,
    parameter int ENABLE_JAL    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       JALFlag,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_fault
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JAL       = 4'd12
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          mem_done;
    logic          timed_out;
    logic [CW-1:0] wait_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        JALFlag     = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        mem_fault   = 1'b0;
        state       = state_q;
        state_d     = S_FETCH;
        // The counter is zero in every non-waiting cycle, which gives the
        // clear-on-entry behaviour for the memory states for free.
        wait_d      = '0;

        mem_done  = (MEM_HANDSHAKE == 0) || mem_ready;
        timed_out = (MEM_HANDSHAKE != 0) && (MEM_TIMEOUT > 0) && !mem_ready &&
                    (wait_q == CW'(MEM_TIMEOUT));
        // With no timeout configured the counter is held at zero.
        wait_inc  = (MEM_TIMEOUT > 0) ? wait_q + CW'(1) : '0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_done) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    // PC was not advanced, so the retry refetches the same word.
                    mem_fault = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_FETCH;
                    wait_d  = wait_inc;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL: begin
                        if (ENABLE_JAL != 0) begin
                            state_d = S_JAL;
                        end else begin
                            illegal_op = 1'b1;
                        end
                    end
                    default:      illegal_op = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_done) begin
                    state_d = S_MEM_WB;
                end else if (timed_out) begin
                    mem_fault = 1'b1;
                end else begin
                    state_d = S_MEM_READ;
                    wait_d  = wait_inc;
                end
            end
            S_MEM_WB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_done) begin
                    instr_done = 1'b1;
                end else if (timed_out) begin
                    mem_fault = 1'b1;
                end else begin
                    state_d = S_MEM_WRITE;
                    wait_d  = wait_inc;
                end
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            S_JAL: begin
                // JALFlag steers the datapath to write PC (already PC+4) into $31.
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                RegWrite   = 1'b1;
                JALFlag    = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                // Unreachable codes 13-15: everything stays 0, recover to FETCH.
                state_d = S_FETCH;
            end
        endcase

        // Reset masks every output in the same cycle so an interrupted
        // memory write or register write is never issued.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            IRWrite     = 1'b0;
            ALUSrcA     = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            JALFlag     = 1'b0;
            PCSource    = 2'b00;
            ALUOp       = 2'b00;
            ALUSrcB     = 2'b00;
            instr_done  = 1'b0;
            illegal_op  = 1'b0;
            mem_fault   = 1'b0;
            state       = 4'd0;
            state_d     = S_FETCH;
            wait_d      = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. Two instances:
//   dut 0: MEM_HANDSHAKE=0, ENABLE_JAL=1
//   dut 1: MEM_HANDSHAKE=1, MEM_TIMEOUT=4, ENABLE_JAL=0
// Expected per-cycle output words come from an instruction-level model that
// expands each instruction into its cycle sequence using a per-state control table.
module tb_multicycle_control;

    localparam int HS_P [2] = '{0, 1};
    localparam int TO_P [2] = '{15, 4};
    localparam int JAL_P[2] = '{1, 0};

    // Bit positions in the packed output word.
    localparam int B_PCW  = 23;
    localparam int B_IRW  = 17;
    localparam int B_RW   = 15;
    localparam int B_DONE = 2;
    localparam int B_ILL  = 1;
    localparam int B_FLT  = 0;

    localparam int K_ILL = 0, K_R = 1, K_LW = 2, K_SW = 3, K_BEQ = 4,
                   K_ADDI = 5, K_J = 6, K_JAL = 7;

    logic        clk = 1'b0;
    logic        rst [2];
    logic [5:0]  op  [2];
    logic        rdy [2];
    logic [23:0] o   [2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
        logic       IRWrite, ALUSrcA, RegWrite, RegDst, JALFlag;
        logic [1:0] PCSource, ALUOp, ALUSrcB;
        logic [3:0] state;
        logic       instr_done, illegal_op, mem_fault;

        multicycle_control #(
            .MEM_HANDSHAKE(HS_P[gi]),
            .MEM_TIMEOUT  (TO_P[gi]),
            .ENABLE_JAL   (JAL_P[gi])
        ) u_dut (
            .clk        (clk),
            .reset      (rst[gi]),
            .Opcode     (op[gi]),
            .mem_ready  (rdy[gi]),
            .PCWrite    (PCWrite),
            .PCWriteCond(PCWriteCond),
            .IorD       (IorD),
            .MemRead    (MemRead),
            .MemWrite   (MemWrite),
            .MemtoReg   (MemtoReg),
            .IRWrite    (IRWrite),
            .ALUSrcA    (ALUSrcA),
            .RegWrite   (RegWrite),
            .RegDst     (RegDst),
            .JALFlag    (JALFlag),
            .PCSource   (PCSource),
            .ALUOp      (ALUOp),
            .ALUSrcB    (ALUSrcB),
            .state      (state),
            .instr_done (instr_done),
            .illegal_op (illegal_op),
            .mem_fault  (mem_fault)
        );

        assign o[gi] = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                        IRWrite, ALUSrcA, RegWrite, RegDst, JALFlag,
                        PCSource, ALUOp, ALUSrcB, state,
                        instr_done, illegal_op, mem_fault};
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] ctl [16];
    logic [23:0] exp_q [$];
    logic        rdy_q [$];
    logic [5:0]  op_q  [$];
    logic [5:0]  cur_op;

    int irw_cnt, irw_idx, rw_cnt, ill_cnt, done_cnt, done_idx, flt_idx;

    typedef struct {
        logic [5:0]      op;
        int              n;
        int              done_cyc;
        logic [4:0][3:0] path;
    } vec_t;
    vec_t tv [7];

    // Field order: pcw pcwc iord mr mw m2r irw asa rw rd jal
    function automatic logic [23:0] mk(logic [10:0] f, logic [1:0] pcs, logic [1:0] aop,
                                       logic [1:0] asb, logic [3:0] st, logic done);
        return {f, pcs, aop, asb, st, done, 2'b00};
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int classify(int k, logic [5:0] opc);
        case (opc)
            6'b000000: return K_R;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b001000: return K_ADDI;
            6'b000010: return K_J;
            6'b000011: return (JAL_P[k] != 0) ? K_JAL : K_ILL;
            default:   return K_ILL;
        endcase
    endfunction

    task automatic put(logic [23:0] w, logic r);
        exp_q.push_back(w);
        rdy_q.push_back(r);
        op_q.push_back(cur_op);
    endtask

    // One memory phase: w ready-low cycles, then completion, or a timeout abort.
    task automatic gen_mem(int k, int st, int w, output bit ok);
        logic [23:0] extra;
        extra = (st == 0) ? ((24'd1 << B_PCW) | (24'd1 << B_IRW)) :
                (st == 5) ? (24'd1 << B_DONE) : 24'd0;
        if (HS_P[k] == 0) begin
            put(ctl[st] | extra, rnd());
            ok = 1'b1;
        end else if (TO_P[k] > 0 && w > TO_P[k]) begin
            for (int i = 0; i <= TO_P[k]; i++)
                put((i == TO_P[k]) ? (ctl[st] | (24'd1 << B_FLT)) : ctl[st], 1'b0);
            ok = 1'b0;
        end else begin
            for (int i = 0; i < w; i++) put(ctl[st], 1'b0);
            put(ctl[st] | extra, 1'b1);
            ok = 1'b1;
        end
    endtask

    task automatic gen_instr(int k, logic [5:0] opc, int wf, int wm);
        bit ok;
        int kind;
        cur_op = opc;
        gen_mem(k, 0, wf, ok);
        if (!ok) return;
        kind = classify(k, opc);
        if (kind == K_ILL) begin
            put(ctl[1] | (24'd1 << B_ILL), rnd());
            return;
        end
        put(ctl[1], rnd());
        case (kind)
            K_R:    begin put(ctl[6], rnd()); put(ctl[7], rnd()); end
            K_LW:   begin
                put(ctl[2], rnd());
                gen_mem(k, 3, wm, ok);
                if (ok) put(ctl[4], rnd());
            end
            K_SW:   begin put(ctl[2], rnd()); gen_mem(k, 5, wm, ok); end
            K_BEQ:  put(ctl[8], rnd());
            K_ADDI: begin put(ctl[10], rnd()); put(ctl[11], rnd()); end
            K_J:    put(ctl[9], rnd());
            K_JAL:  put(ctl[12], rnd());
            default: ;
        endcase
    endtask

    // Called at a falling edge; applies up to n queued cycles and clears the queue.
    task automatic run_queue(int k, int n);
        irw_cnt = 0; irw_idx = -1; rw_cnt = 0; ill_cnt = 0;
        done_cnt = 0; done_idx = -1; flt_idx = -1;
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            op[k]  = op_q[i];
            rdy[k] = rdy_q[i];
            #1;
            if (o[k][B_IRW])  begin irw_cnt++;  irw_idx  = i; end
            if (o[k][B_RW])   rw_cnt++;
            if (o[k][B_ILL])  ill_cnt++;
            if (o[k][B_DONE]) begin done_cnt++; done_idx = i; end
            if (o[k][B_FLT])  flt_idx = i;
            check($sformatf("dut%0d_cyc%0d", k, i), {8'd0, o[k]}, {8'd0, exp_q[i]});
            @(negedge clk);
        end
        exp_q.delete();
        rdy_q.delete();
        op_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [8];
        int cyc;

        for (int i = 0; i < 16; i++) ctl[i] = '0;
        ctl[0]  = mk(11'b00010000000, 2'b00, 2'b00, 2'b01, 4'd0,  1'b0);
        ctl[1]  = mk(11'b00000000000, 2'b00, 2'b00, 2'b11, 4'd1,  1'b0);
        ctl[2]  = mk(11'b00000001000, 2'b00, 2'b00, 2'b10, 4'd2,  1'b0);
        ctl[3]  = mk(11'b00110000000, 2'b00, 2'b00, 2'b00, 4'd3,  1'b0);
        ctl[4]  = mk(11'b00000100100, 2'b00, 2'b00, 2'b00, 4'd4,  1'b1);
        ctl[5]  = mk(11'b00101000000, 2'b00, 2'b00, 2'b00, 4'd5,  1'b0);
        ctl[6]  = mk(11'b00000001000, 2'b00, 2'b10, 2'b00, 4'd6,  1'b0);
        ctl[7]  = mk(11'b00000000110, 2'b00, 2'b00, 2'b00, 4'd7,  1'b1);
        ctl[8]  = mk(11'b01000001000, 2'b01, 2'b01, 2'b00, 4'd8,  1'b1);
        ctl[9]  = mk(11'b10000000000, 2'b10, 2'b00, 2'b00, 4'd9,  1'b1);
        ctl[10] = mk(11'b00000001000, 2'b00, 2'b00, 2'b10, 4'd10, 1'b0);
        ctl[11] = mk(11'b00000000100, 2'b00, 2'b00, 2'b00, 4'd11, 1'b1);
        ctl[12] = mk(11'b10000000101, 2'b10, 2'b00, 2'b00, 4'd12, 1'b1);

        tv[0] = '{op: 6'b000000, n: 4, done_cyc: 4,  path: {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}};
        tv[1] = '{op: 6'b100011, n: 5, done_cyc: 9,  path: {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}};
        tv[2] = '{op: 6'b101011, n: 4, done_cyc: 13, path: {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}};
        tv[3] = '{op: 6'b000100, n: 3, done_cyc: 16, path: {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
        tv[4] = '{op: 6'b001000, n: 4, done_cyc: 20, path: {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}};
        tv[5] = '{op: 6'b000010, n: 3, done_cyc: 23, path: {4'd0, 4'd0, 4'd9, 4'd1, 4'd0}};
        tv[6] = '{op: 6'b000011, n: 3, done_cyc: 26, path: {4'd0, 4'd0, 4'd12, 4'd1, 4'd0}};

        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                6'b001000, 6'b000010, 6'b000011, 6'b111111};

        rst[0] = 1'b1; rst[1] = 1'b1;
        op[0]  = '0;   op[1]  = '0;
        rdy[0] = 1'b1; rdy[1] = 1'b1;

        // Reset held for 3 cycles: every output of both instances is 0.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("reset0_c%0d", i), {8'd0, o[0]}, 32'd0);
            check($sformatf("reset1_c%0d", i), {8'd0, o[1]}, 32'd0);
        end
        $display("reset: 3 cycles held");

        // Release dut 1; first cycle must be FETCH with MemRead and ALUSrcB=01.
        @(negedge clk);
        rst[1] = 1'b0; op[1] = 6'b100011; rdy[1] = 1'b0;
        #1;
        check("first_state",   {28'd0, o[1][6:3]}, 32'd0);
        check("first_memread", {31'd0, o[1][20]},  32'd1);
        check("first_alusrcb", {30'd0, o[1][8:7]}, 32'd1);

        // LW, 2 wait cycles in FETCH and 3 in MEM_READ: 10 cycles in total.
        gen_instr(1, 6'b100011, 2, 3);
        run_queue(1, 1000);
        check("lw_wait_done_idx", done_idx, 9);
        check("lw_wait_irw_cnt",  irw_cnt,  1);
        check("lw_wait_irw_idx",  irw_idx,  2);
        $display("lw with waits: done at cycle index %0d", done_idx);

        // MEM_READ stuck low: fault on the 5th MEM_READ cycle, no register write.
        gen_instr(1, 6'b100011, 0, 99);
        run_queue(1, 1000);
        check("timeout_fault_idx", flt_idx,  7);
        check("timeout_rw_cnt",    rw_cnt,   0);
        check("timeout_done_cnt",  done_cnt, 0);
        $display("lw timeout: fault at cycle index %0d", flt_idx);

        // Illegal opcodes, including JAL on the instance with JAL disabled.
        gen_instr(1, 6'b111111, 0, 0);
        gen_instr(1, 6'b000011, 1, 0);
        run_queue(1, 1000);
        check("illegal_cnt",      ill_cnt,  2);
        check("illegal_done_cnt", done_cnt, 0);
        $display("illegal opcodes: %0d reported", ill_cnt);

        // Reset while MEM_WRITE is waiting: no MemWrite during reset, then FETCH.
        gen_instr(1, 6'b101011, 0, 3);
        run_queue(1, 4);
        rst[1] = 1'b1; rdy[1] = 1'b0;
        #1;
        check("sw_reset_memwrite", {31'd0, o[1][19]}, 32'd0);
        check("sw_reset_outputs",  {8'd0, o[1]},      32'd0);
        @(negedge clk);
        #1;
        check("sw_reset_outputs2", {8'd0, o[1]}, 32'd0);
        @(negedge clk);
        rst[1] = 1'b0;
        gen_instr(1, 6'b000000, 0, 0);
        run_queue(1, 1000);
        $display("reset during mem_write: recovered, R done count %0d", done_cnt);

        // Randomised instruction stream with waits and timeouts on dut 1.
        for (int i = 0; i < 60; i++) begin
            logic [5:0] r_op;
            r_op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) r_op = 6'($urandom);
            gen_instr(1, r_op, $urandom_range(0, 5), $urandom_range(0, 5));
        end
        run_queue(1, 100000);
        $display("random stream dut1 applied");

        // Zero-wait sequence on dut 0.
        rst[1] = 1'b1;
        rst[0] = 1'b0;
        cyc = 0;
        for (int v = 0; v < 7; v++) begin
            for (int c = 0; c < tv[v].n; c++) begin
                op[0]  = tv[v].op;
                rdy[0] = rnd();
                #1;
                cyc++;
                check($sformatf("tv%0d_state%0d", v, c), {28'd0, o[0][6:3]},
                      {28'd0, tv[v].path[c]});
                check($sformatf("tv%0d_done%0d", v, c), {31'd0, o[0][B_DONE]},
                      (c == tv[v].n - 1) ? 32'd1 : 32'd0);
                if (o[0][B_DONE])
                    check($sformatf("tv%0d_done_cycle", v), cyc, tv[v].done_cyc);
                @(negedge clk);
            end
            $display("vector %0d opcode %b: %0d cycles, ends at cycle %0d",
                     v, tv[v].op, tv[v].n, cyc);
        end

        // Randomised stream on dut 0; mem_ready is random and must be ignored.
        for (int i = 0; i < 30; i++)
            gen_instr(0, ops[$urandom_range(0, 7)], 0, 0);
        run_queue(0, 100000);
        $display("random stream dut0 applied");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle MIPS main controller: a Moore FSM that sequences each instruction over 3–5+ cycles, and drives the multicycle datapath's shared memory, IR, PC and ALU-source muxes. It replaces the single-cycle combinational opcode decoder and decodes the same instruction set: R-type, LW, SW, BEQ, ADDI, J and JAL. It adds a memory ready handshake with timeout, an illegal-opcode report and an instruction-complete strobe.

## Interface
Parameters:
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = memory always completes in one cycle (mem_ready ignored).
- MEM_TIMEOUT, 15: maximum wait cycles in a memory state before abort; 0 = no timeout.
- ENABLE_JAL, 1: 0 = opcode 000011 is treated as illegal.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- Opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, JALFlag  out  1 each  datapath controls
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUOp  out  2  00 add, 01 subtract, 10 funct-decoded
- ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- state  out  4  current state encoding (debug)
- instr_done  out  1  one-cycle pulse in the final state of every instruction
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- mem_fault  out  1  one-cycle pulse on a memory timeout

## Operation
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, JAL 12. Codes 13–15 are unreachable; if entered, the FSM goes to FETCH on the next edge with all outputs 0.
- Outputs are pure decode of state (plus mem_ready gating where noted). Every control not listed for a state is 0.
- FETCH: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are asserted only in the cycle that memory completes.
  - Memory completes when mem_ready=1, or every cycle if MEM_HANDSHAKE=0.
  - On completion, next state is DECODE; otherwise the FSM stays in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Opcode:
  - 100011/101011 -> MEM_ADDR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDI_EX
  - 000010 -> JUMP
  - 000011 -> JAL (if ENABLE_JAL)
  - anything else -> FETCH with illegal_op=1
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEM_READ for LW, MEM_WRITE for SW; Opcode is re-sampled here.
- MEM_READ: MemRead, IorD=1. Waits for completion, then -> MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite. instr_done. -> FETCH.
- MEM_WRITE: MemWrite, IorD=1. Waits for completion; instr_done in the completing cycle. -> FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> R_WB.
- R_WB: RegDst=1, MemtoReg=0, RegWrite, instr_done. -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01, instr_done. -> FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDI_WB.
- ADDI_WB: RegDst=0, MemtoReg=0, RegWrite, instr_done. -> FETCH.
- JUMP: PCWrite, PCSource=10, instr_done. -> FETCH.
- JAL: PCWrite, PCSource=10, RegWrite, JALFlag, instr_done. -> FETCH.
  - The datapath uses JALFlag to select $31 as the destination and the current PC (already PC+4) as write data.
- Timeout (MEM_TIMEOUT>0, MEM_HANDSHAKE=1):
  - Wait counter, width clog2(MEM_TIMEOUT+1). It clears on entry to FETCH, MEM_READ or MEM_WRITE and increments on each cycle spent waiting in them.
  - When the counter equals MEM_TIMEOUT and mem_ready=0: mem_fault=1, the memory strobe is still asserted that cycle, no PCWrite/IRWrite/RegWrite, next state is FETCH.
  - A fetch that times out retries at the same PC.
  - mem_ready=1 in the same cycle as the limit counts as completion; no fault.

## Timing
- While reset=1: all outputs 0, state=FETCH, wait counter 0. The first active cycle after release is FETCH.
- Reset asserted mid-instruction aborts it at the next edge; no partial writes are issued in the reset cycle.
- Zero-wait cycle counts (MEM_HANDSHAKE=0): R 4, LW 5, SW 4, ADDI 4, BEQ 3, J 3, JAL 3.
- Each mem_ready wait cycle adds one cycle to FETCH/MEM_READ/MEM_WRITE.
- instr_done, illegal_op and mem_fault are mutually exclusive in any cycle.

## Test plan
- Reset held for 3 cycles, then released:
  - During reset: all outputs 0, state=0.
  - First cycle after release: state=0, MemRead=1, ALUSrcB=01.
- MEM_HANDSHAKE=0; sequence R, LW, SW, BEQ, ADDI, J, JAL:
  - State paths 0-1-6-7, 0-1-2-3-4, 0-1-2-5, 0-1-8, 0-1-10-11, 0-1-9, 0-1-12.
  - instr_done pulses at cycles 4, 9, 13, 16, 20, 23, 26.
- LW with mem_ready low for 2 cycles in FETCH and 3 in MEM_READ:
  - Instruction takes 10 cycles.
  - IRWrite/PCWrite appear only in the FETCH completion cycle.
- MEM_TIMEOUT=4, mem_ready stuck at 0 in MEM_READ:
  - mem_fault=1 on the 5th MEM_READ cycle, then FETCH; RegWrite never asserted.
- Opcode 111111, and 000011 with ENABLE_JAL=0:
  - illegal_op pulse in DECODE, state 1 -> 0, no instr_done.
- Reset asserted in MEM_WRITE while mem_ready=0:
  - MemWrite=0 in the reset cycle; state=0 after the edge.
